mult32x32_ctrl: RTL and testbench
=================================

// Module: mult32x32_ctrl
// PURPOSE
//  Sequencing controller directly upstream of the 32x32 multiplier arithmetic unit.
//  - Accepts a start request and latches both operands.
//  - Drives byte/word selects, shift select and product update/clear strobes through
//    8 partial-product cycles (8-bit A byte x 16-bit B word), then pulses done.
//  - Arith unit accumulates each partial product into its 64-bit product register.
// PARAMETERS
//  RESTART_EN  0  0: start ignored while busy; 1: start while busy aborts and restarts
// PORTS
//  clk        in   1   clock
//  reset      in   1   asynchronous, active-high reset
//  start      in   1   request multiply; sampled on rising edge of clk
//  a_in       in   32  operand A, latched when start accepted
//  b_in       in   32  operand B, latched when start accepted
//  a          out  32  latched operand A to arith unit
//  b          out  32  latched operand B to arith unit
//  a_sel      out  2   A byte select to arith unit
//  b_sel      out  1   B 16-bit word select to arith unit
//  shift_sel  out  3   partial-product shift select (value n = shift by 8*n bits)
//  upd_prod   out  1   accumulate partial product this cycle
//  clr_prod   out  1   clear product register this cycle
//  busy       out  1   high in CLR and MUL states
//  done       out  1   one-cycle pulse: product register holds final result
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, a=b=0; all outputs 0. Takes effect immediately (async).
//  States: IDLE, CLR, MUL, DONE. 3-bit counter cnt is used in MUL only.
//  IDLE/DONE + start=1 at edge:
//    - latch a<=a_in, b<=b_in; go to CLR.
//  IDLE/DONE, no start:
//    - DONE -> IDLE; IDLE holds.
//  CLR: clr_prod=1, busy=1.
//    - Arith unit clears product at the next edge.
//    - Next state MUL, cnt=0.
//  MUL: upd_prod=1, busy=1, a_sel=cnt[1:0], b_sel=cnt[2],
//       shift_sel=a_sel+2*b_sel.
//    - Order by cnt 0..7:
//      (a_sel,b_sel,shift) = (0,0,0) (1,0,1) (2,0,2) (3,0,3)
//                            (0,1,2) (1,1,3) (2,1,4) (3,1,5).
//    - cnt increments each edge; at cnt=7 next state is DONE.
//  DONE: done=1 for exactly one cycle, busy=0.
//    - Product register is already final (8 updates applied).
//  Outputs are decoded from registered state/cnt only; no combinational path from start.
//  Outside MUL: a_sel=b_sel=shift_sel=0, upd_prod=0. clr_prod=0 except in CLR.
//  Latency: start accepted at edge E0; CLR cycle; MUL cycles E1..E9; done high after E9.
//    - start edge to done: 10 cycles. Back-to-back throughput: one result per 10 cycles.
//  Start in DONE: accepted, same as IDLE. done still pulses that cycle.
//  Start while busy, RESTART_EN=0: ignored; operands unchanged; sequence continues.
//  Start while busy, RESTART_EN=1: relatch operands, go to CLR, no done for aborted op.
//  Reset mid-operation: immediate return to IDLE, no done, operands cleared.
//    - Arith product is cleared by its own reset.
//  Operands are unsigned 32-bit; 64-bit result equals a*b exactly (max sum fits, no overflow).
// TESTING
//  1. Reset asserted mid-MUL (cnt=4) -> next cycle: all outputs 0, state IDLE, no done pulse.
//  2. a_in=3, b_in=5, start for 1 cycle -> busy 9 cycles; 1 clr then 8 upd;
//     select order as listed; done 10 cycles after start; product=15.
//  3. a_in=b_in=0xFFFFFFFF -> product=0xFFFFFFFE00000001 at done.
//  4. a_in=0x12345678, b_in=0x9ABCDEF0 -> product=0x0B00EA4E242D2080.
//     Then start again in the DONE cycle with a_in=2, b_in=7 -> second done 10 cycles later,
//     product=14.
//  5. RESTART_EN=0: start pulsed with new operands at cnt=3 -> ignored; first result delivered.
//  6. RESTART_EN=1: same stimulus -> clr_prod next cycle; new product=new a*b;
//     only one done pulse.

Source files
------------

// File: rtl/mult32x32_ctrl.sv
// ============================================================================
// mult32x32_ctrl : sequencing controller for the 32x32 byte-by-word multiplier
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mult32x32_ctrl #(
  parameter bit RESTART_EN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [1:0]  a_sel,
  output logic        b_sel,
  output logic [2:0]  shift_sel,
  output logic        upd_prod,
  output logic        clr_prod,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic       load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
      a     <= 32'd0;
      b     <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        a <= a_in;
        b <= b_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_CLR;
          cnt_nxt   = 3'd0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_CLR: begin
        state_nxt = S_MUL;
        cnt_nxt   = 3'd0;
      end
      S_MUL: begin
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
    // An abort overrides the normal sequence and restarts from the clear cycle.
    if (RESTART_EN && start && (state == S_CLR || state == S_MUL)) begin
      load      = 1'b1;
      state_nxt = S_CLR;
      cnt_nxt   = 3'd0;
    end
  end

  always_comb begin
    a_sel     = 2'd0;
    b_sel     = 1'b0;
    shift_sel = 3'd0;
    upd_prod  = 1'b0;
    clr_prod  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_CLR: begin
        clr_prod = 1'b1;
        busy     = 1'b1;
      end
      S_MUL: begin
        upd_prod  = 1'b1;
        busy      = 1'b1;
        a_sel     = cnt[1:0];
        b_sel     = cnt[2];
        // Word B[31:16] sits two byte positions higher than word B[15:0].
        shift_sel = {1'b0, cnt[1:0]} + {1'b0, cnt[2], 1'b0};
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mult32x32_ctrl.sv
// Scoreboarded bench for mult32x32_ctrl, run against both RESTART_EN settings
// with a behavioural arith unit accumulating the partial products.
`default_nettype none

module tb_mult32x32_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;

  int total = 0;
  int bad   = 0;
  int shift_tab [8] = '{0, 1, 2, 3, 2, 3, 4, 5};

  always #5 clk = ~clk;

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s restart_en=%0d actual=%h required=%h t=%0t", name, inst, act, exp,
               $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit RESTART = (g == 1);

    logic [31:0] a, b;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [2:0]  shift_sel;
    logic        upd_prod, clr_prod, busy, done;
    logic [63:0] prod;
    logic [127:0] q[$];
    int          phase = 0;

    mult32x32_ctrl #(.RESTART_EN(RESTART)) dut (
      .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
      .a(a), .b(b), .a_sel(a_sel), .b_sel(b_sel), .shift_sel(shift_sel),
      .upd_prod(upd_prod), .clr_prod(clr_prod), .busy(busy), .done(done)
    );

    // Downstream arith unit: accumulates byte x word partial products.
    always @(posedge clk or posedge reset) begin
      if (reset) prod <= 64'd0;
      else if (clr_prod) prod <= 64'd0;
      else if (upd_prod)
        prod <= prod + (({56'd0, a[8*a_sel +: 8]} * {48'd0, b[16*b_sel +: 16]})
                        << (8 * shift_sel));
    end

    // Reference timing: phase 0 idle, 1 clear, 2..9 multiply steps, 10 done.
    always @(posedge clk) begin
      if (reset) begin
        phase <= 0;
        q.delete();
      end else if (start && (phase == 0 || phase == 10 || RESTART)) begin
        if (phase >= 1 && phase <= 9) void'(q.pop_back());
        q.push_back({64'(a_in) * 64'(b_in), a_in, b_in});
        phase <= 1;
      end else if (phase == 0 || phase == 10) begin
        phase <= 0;
      end else begin
        phase <= phase + 1;
      end
    end

    always @(negedge clk) begin
      logic [127:0] e;
      int k;
      if (reset) begin
        check("reset_busy", g, 64'(busy), 64'd0);
        check("reset_done", g, 64'(done), 64'd0);
        check("reset_strobes", g, {62'd0, upd_prod, clr_prod}, 64'd0);
        check("reset_sels", g, {58'd0, a_sel, b_sel, shift_sel}, 64'd0);
        check("reset_operands", g, {a, b}, 64'd0);
      end else begin
        k = (phase >= 2 && phase <= 9) ? phase - 2 : 0;
        check("busy", g, 64'(busy), 64'(phase >= 1 && phase <= 9));
        check("done", g, 64'(done), 64'(phase == 10));
        check("clr_prod", g, 64'(clr_prod), 64'(phase == 1));
        check("upd_prod", g, 64'(upd_prod), 64'(phase >= 2 && phase <= 9));
        if (phase >= 2 && phase <= 9) begin
          check("a_sel", g, 64'(a_sel), 64'(k % 4));
          check("b_sel", g, 64'(b_sel), 64'(k / 4));
          check("shift_sel", g, 64'(shift_sel), 64'(shift_tab[k]));
        end else begin
          check("idle_sels", g, {58'd0, a_sel, b_sel, shift_sel}, 64'd0);
        end
        if (done) begin
          if (q.size() == 0) begin
            check("unexpected_done", g, 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check("product", g, prod, e[127:64]);
            check("operands", g, {a, b}, e[63:0]);
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic op(input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    a_in  = x;
    b_in  = y;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);

    op(32'd3, 32'd5);
    tick(12);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(12);

    // Second start lands in the DONE cycle.
    op(32'h1234_5678, 32'h9ABC_DEF0);
    tick(9);
    op(32'd2, 32'd7);
    tick(12);

    // Start while multiplying at cnt=3.
    op(32'hDEAD_BEEF, 32'h0000_1234);
    tick(4);
    op(32'h0000_0100, 32'h0001_0001);
    tick(14);

    // Reset during cnt=4.
    op(32'hCAFE_F00D, 32'h1357_9BDF);
    tick(5);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(12);

    for (int n = 0; n < 40; n++) begin
      start = 1'b1;
      a_in  = $urandom;
      b_in  = $urandom;
      tick($urandom_range(1, 2));
      start = 1'b0;
      tick($urandom_range(0, 12));
    end
    tick(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
